// File: rtl/cabac_pkg.sv
// Shared constants for the CABAC low-update stage.
//   LOW_W        : width of the coder low register
//   OUT_W        : maximum number of bits emitted per cycle
//   MAX_REG_BINS : regular bins handled per cycle
//   MAX_BINS     : total bin slots per cycle
//   ACC_W        : width of the per-cycle low accumulator
package cabac_pkg;
  localparam int unsigned LOW_W        = 9;
  localparam int unsigned OUT_W        = 32;
  localparam int unsigned MAX_REG_BINS = 4;
  localparam int unsigned MAX_BINS     = 8;
  localparam int unsigned ACC_W        = 42;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH_PEND = 2'd1,
    ST_FLUSH      = 2'd2
  } ulow_state_t;
endpackage

// File: rtl/cabac_ulow4_step.sv
// Combinational single-slot low update.
//   a_in/a_out : accumulator before/after this slot
//   active     : slot lies within number_all
//   bypass     : slot is a bypass bin (else regular)
//   reg_ok     : regular slot maps to one of the 4 regular bins
//   lpsmps, range_j, rlps_j, shift_j : selected regular-bin data
//   sym        : bypass bin value
//   nbits      : bits produced by this slot
module cabac_ulow4_step
  import cabac_pkg::*;
(
  input  logic [ACC_W-1:0] a_in,
  input  logic             active,
  input  logic             bypass,
  input  logic             reg_ok,
  input  logic             lpsmps,
  input  logic [7:0]       range_j,
  input  logic [7:0]       rlps_j,
  input  logic [2:0]       shift_j,
  input  logic             sym,
  output logic [ACC_W-1:0] a_out,
  output logic [2:0]       nbits
);
  logic [7:0] diff;

  always_comb begin
    a_out = a_in;
    nbits = '0;
    diff  = '0;
    if (active) begin
      if (bypass) begin
        a_out = (a_in << 1) + ACC_W'(sym ? range_j : 8'd0);
        nbits = 3'd1;
      end else if (reg_ok) begin
        if (lpsmps) diff = range_j - rlps_j;
        a_out = (a_in + ACC_W'(diff)) << shift_j;
        nbits = shift_j;
      end
    end
  end
endmodule

// File: rtl/cabac_ulow4.sv
// CABAC low-update stage, up to 4 regular + bypass bins per cycle.
//   clk, rst (sync, active-high), en (slice enable, low clears)
//   enable/flush : input valid and end-of-slice flush request
//   number_all, index_bypass, symbol_bypass : slot descriptors
//   lpsmps_*, range_*, rlps_*, shift_* : registered range-stage outputs
//   out_valid, out_bit_num, out_bits, out_carry : emitted bits for packer
//   out_low : current low register
module cabac_ulow4
  import cabac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             enable,
  input  logic             flush,
  input  logic [3:0]       number_all,
  input  logic [7:0]       index_bypass,
  input  logic [7:0]       symbol_bypass,
  input  logic             lpsmps_0,
  input  logic             lpsmps_1,
  input  logic             lpsmps_2,
  input  logic             lpsmps_3,
  input  logic [7:0]       range_0,
  input  logic [7:0]       range_1,
  input  logic [7:0]       range_2,
  input  logic [7:0]       range_3,
  input  logic [7:0]       range_4,
  input  logic [7:0]       rlps_0,
  input  logic [7:0]       rlps_1,
  input  logic [7:0]       rlps_2,
  input  logic [7:0]       rlps_3,
  input  logic [2:0]       shift_0,
  input  logic [2:0]       shift_1,
  input  logic [2:0]       shift_2,
  input  logic [2:0]       shift_3,
  output logic             out_valid,
  output logic [5:0]       out_bit_num,
  output logic [OUT_W-1:0] out_bits,
  output logic             out_carry,
  output logic [LOW_W-1:0] out_low
);
  ulow_state_t state, state_nxt;
  logic [LOW_W-1:0] low, low_nxt;

  logic [3:0]       nall;
  logic [2:0]       jcnt;
  logic             slot_act [MAX_BINS];
  logic             slot_rok [MAX_BINS];
  logic             sel_lps  [MAX_BINS];
  logic [7:0]       sel_rng  [MAX_BINS];
  logic [7:0]       sel_rlps [MAX_BINS];
  logic [2:0]       sel_sh   [MAX_BINS];
  logic [2:0]       slot_nb  [MAX_BINS];
  logic [ACC_W-1:0] acc      [MAX_BINS+1];

  logic [5:0]       s_tot;
  logic [ACC_W-1:0] acc_hi, mask;
  logic             valid_nxt, carry_nxt;
  logic [5:0]       num_nxt;
  logic [OUT_W-1:0] bits_nxt;

  // Regular-index mux: each slot sees the regular-bin data of the count of
  // regular slots ahead of it; the count saturates at 4 so trailing bypass
  // bins pick up range_4 and extra regular slots are dropped.
  always_comb begin
    nall = (number_all > 4'd8) ? 4'd8 : number_all;
    jcnt = '0;
    for (int unsigned k = 0; k < MAX_BINS; k++) begin
      slot_act[k] = (k < 32'(nall));
      slot_rok[k] = (jcnt < 3'd4);
      case (jcnt)
        3'd0:    begin sel_lps[k] = lpsmps_0; sel_rng[k] = range_0; sel_rlps[k] = rlps_0; sel_sh[k] = shift_0; end
        3'd1:    begin sel_lps[k] = lpsmps_1; sel_rng[k] = range_1; sel_rlps[k] = rlps_1; sel_sh[k] = shift_1; end
        3'd2:    begin sel_lps[k] = lpsmps_2; sel_rng[k] = range_2; sel_rlps[k] = rlps_2; sel_sh[k] = shift_2; end
        3'd3:    begin sel_lps[k] = lpsmps_3; sel_rng[k] = range_3; sel_rlps[k] = rlps_3; sel_sh[k] = shift_3; end
        default: begin sel_lps[k] = 1'b0;     sel_rng[k] = range_4; sel_rlps[k] = '0;     sel_sh[k] = '0;      end
      endcase
      if (slot_act[k] && !index_bypass[k] && jcnt < 3'd4) jcnt = jcnt + 3'd1;
    end
  end

  assign acc[0] = ACC_W'(low);

  for (genvar k = 0; k < MAX_BINS; k++) begin : g_step
    cabac_ulow4_step u_step (
      .a_in    (acc[k]),
      .active  (slot_act[k]),
      .bypass  (index_bypass[k]),
      .reg_ok  (slot_rok[k]),
      .lpsmps  (sel_lps[k]),
      .range_j (sel_rng[k]),
      .rlps_j  (sel_rlps[k]),
      .shift_j (sel_sh[k]),
      .sym     (symbol_bypass[k]),
      .a_out   (acc[k+1]),
      .nbits   (slot_nb[k])
    );
  end

  always_comb begin
    s_tot = '0;
    for (int unsigned k = 0; k < MAX_BINS; k++) s_tot = s_tot + 6'(slot_nb[k]);
    acc_hi = acc[MAX_BINS] >> LOW_W;
    mask   = (ACC_W'(1) << s_tot) - ACC_W'(1);
  end

  always_comb begin
    state_nxt = ST_RUN;
    low_nxt   = low;
    valid_nxt = 1'b0;
    num_nxt   = '0;
    bits_nxt  = '0;
    carry_nxt = 1'b0;
    case (state)
      ST_FLUSH_PEND: begin
        state_nxt = ST_FLUSH;
        valid_nxt = 1'b1;
        num_nxt   = 6'(LOW_W);
        bits_nxt  = OUT_W'(low);
        low_nxt   = '0;
      end
      default: begin
        if (enable) begin
          state_nxt = flush ? ST_FLUSH_PEND : ST_RUN;
          valid_nxt = 1'b1;
          num_nxt   = s_tot;
          bits_nxt  = OUT_W'(acc_hi & mask);
          carry_nxt = acc_hi[s_tot];
          low_nxt   = acc[MAX_BINS][LOW_W-1:0];
        end else if (flush) begin
          state_nxt = ST_FLUSH;
          valid_nxt = 1'b1;
          num_nxt   = 6'(LOW_W);
          bits_nxt  = OUT_W'(low);
          low_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state       <= ST_RUN;
      low         <= '0;
      out_valid   <= 1'b0;
      out_bit_num <= '0;
      out_bits    <= '0;
      out_carry   <= 1'b0;
    end else begin
      state       <= state_nxt;
      low         <= low_nxt;
      out_valid   <= valid_nxt;
      out_bit_num <= num_nxt;
      out_bits    <= bits_nxt;
      out_carry   <= carry_nxt;
    end
  end

  assign out_low = low;
endmodule

// File: tb/tb_cabac_ulow4.sv
module tb_cabac_ulow4;
  logic        clk = 1'b0;
  logic        rst, en, enable, flush;
  logic [3:0]  number_all;
  logic [7:0]  index_bypass, symbol_bypass;
  logic        lpsmps_0, lpsmps_1, lpsmps_2, lpsmps_3;
  logic [7:0]  range_0, range_1, range_2, range_3, range_4;
  logic [7:0]  rlps_0, rlps_1, rlps_2, rlps_3;
  logic [2:0]  shift_0, shift_1, shift_2, shift_3;
  logic        out_valid, out_carry;
  logic [5:0]  out_bit_num;
  logic [31:0] out_bits;
  logic [8:0]  out_low;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  cabac_ulow4 dut (
    .clk(clk), .rst(rst), .en(en), .enable(enable), .flush(flush),
    .number_all(number_all), .index_bypass(index_bypass), .symbol_bypass(symbol_bypass),
    .lpsmps_0(lpsmps_0), .lpsmps_1(lpsmps_1), .lpsmps_2(lpsmps_2), .lpsmps_3(lpsmps_3),
    .range_0(range_0), .range_1(range_1), .range_2(range_2), .range_3(range_3), .range_4(range_4),
    .rlps_0(rlps_0), .rlps_1(rlps_1), .rlps_2(rlps_2), .rlps_3(rlps_3),
    .shift_0(shift_0), .shift_1(shift_1), .shift_2(shift_2), .shift_3(shift_3),
    .out_valid(out_valid), .out_bit_num(out_bit_num), .out_bits(out_bits),
    .out_carry(out_carry), .out_low(out_low)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    enable = 1'b0; flush = 1'b0; number_all = '0;
    index_bypass = '0; symbol_bypass = '0;
    lpsmps_0 = 0; lpsmps_1 = 0; lpsmps_2 = 0; lpsmps_3 = 0;
    range_0 = 8'd200; range_1 = 8'd200; range_2 = 8'd200; range_3 = 8'd200; range_4 = 8'd200;
    rlps_0 = 0; rlps_1 = 0; rlps_2 = 0; rlps_3 = 0;
    shift_0 = 0; shift_1 = 0; shift_2 = 0; shift_3 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input int unsigned n,
                         input logic [31:0] b, input logic c, input int unsigned l);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".num"},   32'(out_bit_num), n);
    check({tag, ".bits"},  out_bits, b);
    check({tag, ".carry"}, 32'(out_carry), 32'(c));
    check({tag, ".low"},   32'(out_low), l);
  endtask

  initial begin
    clr_in();
    rst = 1'b1; en = 1'b1;
    tick();
    check("rst.valid", 32'(out_valid), 0);
    check("rst.low", 32'(out_low), 0);
    rst = 1'b0;

    // Regular MPS, no shift
    enable = 1; number_all = 1; shift_0 = 0;
    tick(); chk_out("mps", 1, 0, 0, 0, 0);

    // LPS 200/50 shift 1: 150<<1 = 300
    lpsmps_0 = 1; range_0 = 200; rlps_0 = 50; shift_0 = 1;
    tick(); chk_out("lps1", 1, 1, 0, 0, 300);

    // LPS 200/60 shift 2: (300+140)<<2 = 1760 -> bits 11, low 224
    range_0 = 200; rlps_0 = 60; shift_0 = 2;
    tick(); chk_out("lps2", 1, 2, 3, 0, 224);

    // 224+240 = 464, then 704 -> carry, low 192
    range_0 = 250; rlps_0 = 10; shift_0 = 0;
    tick(); chk_out("cy0", 1, 0, 0, 0, 464);
    tick(); chk_out("cy1", 1, 0, 0, 1, 192);

    // Idle holds low
    clr_in();
    tick(); chk_out("idle", 0, 0, 0, 0, 192);

    // en low clears low
    en = 0;
    tick(); chk_out("en0", 0, 0, 0, 0, 0);
    en = 1;

    // Two bypass bins: (0<<1)+200 = 200, <<1 = 400
    enable = 1; number_all = 2; index_bypass = 8'b11; symbol_bypass = 8'b01; range_0 = 200;
    tick(); chk_out("byp", 1, 2, 0, 0, 400);

    // number_all = 0 leaves low unchanged
    clr_in(); enable = 1; number_all = 0;
    tick(); chk_out("n0", 1, 0, 0, 0, 400);

    // Flush alone
    clr_in(); flush = 1;
    tick(); chk_out("fl", 1, 9, 32'd400, 0, 0);
    clr_in();
    tick(); check("fl.after", 32'(out_valid), 0);

    // Mixed: reg(LPS 200/50 sh1)=300, byp sym1 range_1=180 -> 780, reg MPS sh2 -> 3120
    enable = 1; number_all = 3; index_bypass = 8'b010; symbol_bypass = 8'b010;
    lpsmps_0 = 1; range_0 = 200; rlps_0 = 50; shift_0 = 1;
    range_1 = 180; lpsmps_1 = 0; shift_1 = 2;
    tick(); chk_out("mix", 1, 4, 6, 0, 48);

    // Flush together with enable: MPS sh1 -> 96, then flush of 96
    clr_in(); enable = 1; flush = 1; number_all = 1; shift_0 = 1;
    tick(); chk_out("fe0", 1, 1, 0, 0, 96);
    clr_in();
    tick(); chk_out("fe1", 1, 9, 32'd96, 0, 0);
    tick(); check("fe2.valid", 32'(out_valid), 0);

    // Five regular slots: 5th dropped. 150<<1=300,600,1200,2400
    enable = 1; number_all = 5;
    lpsmps_0 = 1; range_0 = 200; rlps_0 = 50;
    shift_0 = 1; shift_1 = 1; shift_2 = 1; shift_3 = 1;
    tick(); chk_out("reg5", 1, 4, 4, 0, 352);

    // Bypass after 4 regulars uses range_4: 352<<1 + 77 = 781
    clr_in(); enable = 1; number_all = 6; index_bypass = 8'b100000;
    symbol_bypass = 8'b100000; range_4 = 77;
    tick(); chk_out("byp_r4", 1, 1, 1, 0, 269);

    // Mid-run reset
    clr_in(); rst = 1; enable = 1; number_all = 1; shift_0 = 3;
    tick(); chk_out("rst2", 0, 0, 0, 0, 0);
    rst = 0; clr_in();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
